// File: rtl/sw_pkt_tx.sv
// ---------------------------------------------------------------------------
// sw_pkt_tx
// Builds a frame for the switch ingress from a header request and a
// buffered payload: DA, SA, LEN, then payload bytes, sent back to back
// with sw_enable_out high. Each frame is followed by IPG_CYCLES idle
// cycles.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   pkt_valid/ready    header handshake; pkt_da, pkt_sa, pkt_len sampled
//   pl_data/valid/rdy  payload byte stream, accepted only while loading
//   sw_enable_out      high for every frame byte
//   data_out           frame byte, 0 when sw_enable_out is low
//   busy               high outside IDLE
//   pkt_done           one-cycle pulse in the first gap cycle
//   err_oversize       one-cycle pulse when a header has len > FIFO_SIZE
//   pkt_count          completed-frame counter, wraps at 16 bits
//
// state  | meaning
// IDLE   | waiting for a header (pkt_ready high)
// LOAD   | accepting len payload beats into the buffer
// TX_DA  | data_out shows destination address
// TX_SA  | data_out shows source address
// TX_LEN | data_out shows payload length
// TX_PL  | data_out shows a payload byte
// GAP    | inter-packet idle, IPG_CYCLES long
// ---------------------------------------------------------------------------
module sw_pkt_tx #(
    parameter int WORD_WIDTH = 8,
    parameter int FIFO_SIZE  = 64,
    parameter int IPG_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pkt_valid,
    input  logic [WORD_WIDTH-1:0] pkt_da,
    input  logic [WORD_WIDTH-1:0] pkt_sa,
    input  logic [WORD_WIDTH-1:0] pkt_len,
    output logic                  pkt_ready,
    input  logic [WORD_WIDTH-1:0] pl_data,
    input  logic                  pl_valid,
    output logic                  pl_ready,
    output logic                  sw_enable_out,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  pkt_done,
    output logic                  err_oversize,
    output logic [15:0]           pkt_count
);

    localparam int AW = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
    localparam int GW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(IPG_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, TX_DA, TX_SA, TX_LEN, TX_PL, GAP} state_t;

    state_t                state, state_d;
    logic [WORD_WIDTH-1:0] da_q, da_d, sa_q, sa_d, len_q, len_d;
    logic [WORD_WIDTH-1:0] rem_q, rem_d;
    logic [AW-1:0]         wr_ptr, wr_d, rd_ptr, rd_d;
    logic [GW-1:0]         gap_cnt, gap_d;
    logic                  en_d, done_d, err_d, wr_en;
    logic [WORD_WIDTH-1:0] dout_d;
    logic                  hdr_fire, beat;

    logic [WORD_WIDTH-1:0] buf_mem [FIFO_SIZE];

    assign hdr_fire = pkt_valid & pkt_ready;
    assign beat     = pl_valid & pl_ready;

    always_comb begin
        state_d = state;
        da_d    = da_q;
        sa_d    = sa_q;
        len_d   = len_q;
        rem_d   = rem_q;
        wr_d    = wr_ptr;
        rd_d    = rd_ptr;
        gap_d   = gap_cnt;
        en_d    = 1'b0;
        dout_d  = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        case (state)
            IDLE: begin
                if (hdr_fire) begin
                    da_d  = pkt_da;
                    sa_d  = pkt_sa;
                    len_d = pkt_len;
                    rem_d = pkt_len;
                    wr_d  = '0;
                    rd_d  = '0;
                    if (32'(pkt_len) > FIFO_SIZE) begin
                        err_d = 1'b1;
                    end else if (pkt_len == '0) begin
                        state_d = TX_DA;
                        en_d    = 1'b1;
                        dout_d  = pkt_da;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (beat) begin
                    wr_en = 1'b1;
                    wr_d  = wr_ptr + AW'(1);
                    rem_d = rem_q - 1'b1;
                    if (rem_q == WORD_WIDTH'(1)) begin
                        state_d = TX_DA;
                        en_d    = 1'b1;
                        dout_d  = da_q;
                    end
                end
            end
            TX_DA: begin
                state_d = TX_SA;
                en_d    = 1'b1;
                dout_d  = sa_q;
                rem_d   = len_q;
            end
            TX_SA: begin
                state_d = TX_LEN;
                en_d    = 1'b1;
                dout_d  = len_q;
            end
            TX_LEN, TX_PL: begin
                // rem_q counts payload bytes still to be shown
                if (rem_q == '0) begin
                    state_d = GAP;
                    done_d  = 1'b1;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = TX_PL;
                    en_d    = 1'b1;
                    dout_d  = buf_mem[rd_ptr];
                    rd_d    = rd_ptr + AW'(1);
                    rem_d   = rem_q - 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_d = IDLE;
                else               gap_d   = gap_cnt - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            da_q          <= '0;
            sa_q          <= '0;
            len_q         <= '0;
            rem_q         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            gap_cnt       <= '0;
            pkt_ready     <= 1'b0;
            pl_ready      <= 1'b0;
            sw_enable_out <= 1'b0;
            data_out      <= '0;
            busy          <= 1'b0;
            pkt_done      <= 1'b0;
            err_oversize  <= 1'b0;
            pkt_count     <= '0;
        end else begin
            state         <= state_d;
            da_q          <= da_d;
            sa_q          <= sa_d;
            len_q         <= len_d;
            rem_q         <= rem_d;
            wr_ptr        <= wr_d;
            rd_ptr        <= rd_d;
            gap_cnt       <= gap_d;
            pkt_ready     <= (state_d == IDLE);
            pl_ready      <= (state_d == LOAD);
            sw_enable_out <= en_d;
            data_out      <= dout_d;
            busy          <= (state_d != IDLE);
            pkt_done      <= done_d;
            err_oversize  <= err_d;
            if (done_d) pkt_count <= pkt_count + 16'd1;
        end
    end

    // Buffer contents are never reset; pointers restart with every header.
    always_ff @(posedge clk) begin
        if (wr_en) buf_mem[wr_ptr] <= pl_data;
    end

endmodule

// File: tb/tb_sw_pkt_tx.sv
// ---------------------------------------------------------------------------
// tb_sw_pkt_tx
// Directed bench for sw_pkt_tx with default parameters (8-bit words,
// 64-deep buffer, 2 gap cycles). Outputs are sampled 1 time unit after
// the rising edge; expected values are written out by hand below.
// ---------------------------------------------------------------------------
module tb_sw_pkt_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pkt_valid = 1'b0;
    logic [7:0]  pkt_da = '0, pkt_sa = '0, pkt_len = '0;
    logic        pkt_ready;
    logic [7:0]  pl_data = '0;
    logic        pl_valid = 1'b0;
    logic        pl_ready;
    logic        sw_enable_out;
    logic [7:0]  data_out;
    logic        busy, pkt_done, err_oversize;
    logic [15:0] pkt_count;

    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] exp_cnt = '0;
    logic [7:0]  exp_pl [64];

    sw_pkt_tx dut (
        .clk(clk), .rst_n(rst_n),
        .pkt_valid(pkt_valid), .pkt_da(pkt_da), .pkt_sa(pkt_sa), .pkt_len(pkt_len),
        .pkt_ready(pkt_ready),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .sw_enable_out(sw_enable_out), .data_out(data_out),
        .busy(busy), .pkt_done(pkt_done), .err_oversize(err_oversize),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $error("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Waits for pkt_ready, then completes the handshake on the next edge.
    task automatic send_header(input logic [7:0] da, input logic [7:0] sa,
                               input logic [7:0] len, input bit hold);
        int waited = 0;
        pkt_da = da; pkt_sa = sa; pkt_len = len; pkt_valid = 1'b1;
        while (pkt_ready !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        chk("hdr_wait", {31'd0, pkt_ready}, 32'd1);
        tick();
        if (!hold) pkt_valid = 1'b0;
    endtask

    // Feeds n payload bytes from exp_pl with one idle cycle between beats.
    task automatic feed_payload(input int n);
        for (int i = 0; i < n; i++) begin
            int waited = 0;
            pl_data  = exp_pl[i];
            pl_valid = 1'b1;
            while (pl_ready !== 1'b1 && waited < 200) begin
                tick();
                waited++;
            end
            if (pl_ready !== 1'b1) chk("pl_wait", {31'd0, pl_ready}, 32'd1);
            tick();
            pl_valid = 1'b0;
            pl_data  = 8'hEE;
            if (i < n - 1) tick();
        end
    endtask

    // Called at the sample where the DA byte should be showing.
    task automatic check_frame(input string tag, input logic [7:0] da,
                               input logic [7:0] sa, input int len);
        logic [7:0] exp_b;
        for (int k = 0; k < 3 + len; k++) begin
            if (k == 0)      exp_b = da;
            else if (k == 1) exp_b = sa;
            else if (k == 2) exp_b = 8'(len);
            else             exp_b = exp_pl[k-3];
            chk($sformatf("%s_en[%0d]", tag, k), {31'd0, sw_enable_out}, 32'd1);
            chk($sformatf("%s_byte[%0d]", tag, k), {24'd0, data_out}, {24'd0, exp_b});
            tick();
        end
        exp_cnt = exp_cnt + 16'd1;
        chk({tag, "_gap0_en"}, {31'd0, sw_enable_out}, 32'd0);
        chk({tag, "_gap0_data"}, {24'd0, data_out}, 32'd0);
        chk({tag, "_done"}, {31'd0, pkt_done}, 32'd1);
        chk({tag, "_count"}, {16'd0, pkt_count}, {16'd0, exp_cnt});
        tick();
        chk({tag, "_gap1_en"}, {31'd0, sw_enable_out}, 32'd0);
        chk({tag, "_gap1_done"}, {31'd0, pkt_done}, 32'd0);
        chk({tag, "_gap1_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_gap1_ready"}, {31'd0, pkt_ready}, 32'd0);
        tick();
        chk({tag, "_idle_ready"}, {31'd0, pkt_ready}, 32'd1);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] b2b_data [9];
        logic       b2b_en   [9];
        b2b_data = '{8'h02, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h11, 8'h00};
        b2b_en   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        // reset state
        #12;
        chk("rst_en", {31'd0, sw_enable_out}, 32'd0);
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_pkt_ready", {31'd0, pkt_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {16'd0, pkt_count}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_pkt_ready_pre", {31'd0, pkt_ready}, 32'd0);
        tick();
        chk("rel_pkt_ready_post", {31'd0, pkt_ready}, 32'd1);

        // len = 0 frame
        send_header(8'h02, 8'h11, 8'h00, 1'b0);
        check_frame("len0", 8'h02, 8'h11, 0);

        // len = 4, payload A0..A3 with toggling pl_valid
        for (int i = 0; i < 4; i++) exp_pl[i] = 8'hA0 + 8'(i);
        send_header(8'h02, 8'h11, 8'h04, 1'b0);
        chk("len4_pl_ready", {31'd0, pl_ready}, 32'd1);
        chk("len4_load_en", {31'd0, sw_enable_out}, 32'd0);
        feed_payload(4);
        check_frame("len4", 8'h02, 8'h11, 4);
        chk("len4_pl_ready_after", {31'd0, pl_ready}, 32'd0);

        // oversize header rejected
        send_header(8'h02, 8'h11, 8'd65, 1'b0);
        chk("ovr_err", {31'd0, err_oversize}, 32'd1);
        chk("ovr_en", {31'd0, sw_enable_out}, 32'd0);
        chk("ovr_busy", {31'd0, busy}, 32'd0);
        chk("ovr_pl_ready", {31'd0, pl_ready}, 32'd0);
        tick();
        chk("ovr_err_clear", {31'd0, err_oversize}, 32'd0);
        chk("ovr_en2", {31'd0, sw_enable_out}, 32'd0);
        chk("ovr_count", {16'd0, pkt_count}, {16'd0, exp_cnt});
        chk("ovr_ready", {31'd0, pkt_ready}, 32'd1);

        // full buffer, len = 64
        for (int i = 0; i < 64; i++) exp_pl[i] = 8'(i) ^ 8'h5A;
        send_header(8'h33, 8'h44, 8'd64, 1'b0);
        feed_payload(64);
        check_frame("len64", 8'h33, 8'h44, 64);

        // back-to-back len = 0 with pkt_valid held high
        send_header(8'h02, 8'h11, 8'h00, 1'b1);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("b2b_en[%0d]", i), {31'd0, sw_enable_out}, {31'd0, b2b_en[i]});
            chk($sformatf("b2b_byte[%0d]", i), {24'd0, data_out}, {24'd0, b2b_data[i]});
            if (i == 3) chk("b2b_done1", {31'd0, pkt_done}, 32'd1);
            if (i == 6) pkt_valid = 1'b0;
            tick();
        end
        exp_cnt = exp_cnt + 16'd2;
        chk("b2b_done2", {31'd0, pkt_done}, 32'd1);
        chk("b2b_count", {16'd0, pkt_count}, {16'd0, exp_cnt});
        tick();
        tick();
        chk("b2b_idle", {31'd0, pkt_ready}, 32'd1);

        // reset in the middle of the payload
        for (int i = 0; i < 4; i++) exp_pl[i] = 8'hC0 + 8'(i);
        send_header(8'h05, 8'h06, 8'h04, 1'b0);
        feed_payload(4);
        for (int i = 0; i < 4; i++) tick();
        chk("mid_before_byte", {24'd0, data_out}, 32'h0000_00C1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", {31'd0, sw_enable_out}, 32'd0);
        chk("mid_rst_data", {24'd0, data_out}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_pkt_ready", {31'd0, pkt_ready}, 32'd0);
        chk("mid_rst_count", {16'd0, pkt_count}, 32'd0);
        #7;
        rst_n = 1'b1;
        exp_cnt = '0;
        tick();
        chk("mid_rel_ready", {31'd0, pkt_ready}, 32'd1);
        chk("mid_rel_en", {31'd0, sw_enable_out}, 32'd0);
        exp_pl[0] = 8'h7E;
        send_header(8'h09, 8'h0A, 8'h01, 1'b0);
        feed_payload(1);
        check_frame("post_rst", 8'h09, 8'h0A, 1);

        // counter wrap
        force dut.pkt_count = 16'hFFFF;
        #1;
        release dut.pkt_count;
        chk("wrap_preload", {16'd0, pkt_count}, 32'h0000_FFFF);
        exp_cnt = 16'hFFFF;
        send_header(8'h02, 8'h11, 8'h00, 1'b0);
        check_frame("wrap", 8'h02, 8'h11, 0);
        chk("wrap_zero", {16'd0, pkt_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sw_pkt_tx.md
SW_PKT_TX -- requirements
Module: sw_pkt_tx

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8: width of every data byte and header field.
REQ-002 SHALL have parameter FIFO_SIZE, default 64: payload buffer depth in words; the maximum payload length.
REQ-003 SHALL have parameter IPG_CYCLES, default 2: number of idle cycles between packets; legal range is 1 or more.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; clock `clk` and reset `rst_n` are the first two ports.
REQ-005 SHALL have port clk, input, width 1: rising-edge clock.
REQ-006 SHALL have port rst_n, input, width 1: asynchronous active-low reset.
REQ-007 SHALL have port pkt_valid, input, width 1: a packet header request is present.
REQ-008 SHALL have port pkt_da, pkt_sa and pkt_len, inputs, each WORD_WIDTH: destination address, source address and payload length, sampled at header handshake.
REQ-009 SHALL have port pkt_ready, output, width 1: the block accepts a header.
REQ-010 SHALL have port pl_data, input, WORD_WIDTH: payload byte.
REQ-011 SHALL have port pl_valid, input, width 1: pl_data is valid.
REQ-012 SHALL have port pl_ready, output, width 1: the block accepts a payload byte.
REQ-013 SHALL have port sw_enable_out, output, width 1: frame enable to the switch ingress, high for every packet byte.
REQ-014 SHALL have port data_out, output, WORD_WIDTH: packet byte to the switch ingress.
REQ-015 SHALL have port busy, output, width 1: high in any state other than IDLE.
REQ-016 SHALL have port pkt_done, output, width 1: one-cycle pulse when a packet finishes.
REQ-017 SHALL have port err_oversize, output, width 1: one-cycle pulse when a header is rejected.
REQ-018 SHALL have port pkt_count, output, width 16: count of completed packets.

Function
REQ-019 SHALL implement the states IDLE, LOAD, TX_DA, TX_SA, TX_LEN, TX_PL and GAP; all outputs SHALL be registered.
REQ-020 SHALL drive pkt_ready high only in IDLE; a header handshake is pkt_valid and pkt_ready both high at a rising edge, and the block SHALL latch da, sa and len on that edge.
REQ-021 SHALL, on a header handshake with len > FIFO_SIZE, pulse err_oversize in the next cycle, leave pkt_count unchanged and stay in IDLE.
REQ-022 SHALL, on a header handshake with len = 0, go to TX_DA; with 1 <= len <= FIFO_SIZE it SHALL go to LOAD.
REQ-023 SHALL, in LOAD, drive pl_ready high until len beats are accepted; a beat is pl_valid and pl_ready both high; the block SHALL write beats to the buffer in order and go to TX_DA after the last beat; pl_valid low stalls LOAD with no timeout.
REQ-024 SHALL ignore pl_data and pl_valid outside LOAD; pl_ready SHALL be low outside LOAD.
REQ-025 SHALL, from TX_DA, emit on consecutive cycles with sw_enable_out=1: DA, SA, LEN, then payload bytes in arrival order; it SHALL never deassert sw_enable_out mid-packet.
REQ-026 SHALL make the first packet byte appear on data_out in the cycle after the handshake edge (len=0) or after the last-beat edge (len>0); a packet occupies exactly 3+len cycles.
REQ-027 SHALL enter GAP after the last byte, with sw_enable_out=0 and data_out=0 for IPG_CYCLES cycles, then return to IDLE.
REQ-028 SHALL pulse pkt_done and increment pkt_count in the first GAP cycle; pkt_count SHALL wrap from 16'hFFFF to 0.
REQ-029 SHALL hold data_out at 0 whenever sw_enable_out=0.
REQ-030 SHALL address the buffer with a read pointer, write pointer and length counter, each reset per packet; with len=FIFO_SIZE the buffer fills exactly, with no overflow and no wrap across packets.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force state IDLE, sw_enable_out=0, data_out=0, pkt_ready=0, pl_ready=0, busy=0, pkt_done=0, err_oversize=0 and pkt_count=0.
REQ-032 SHALL drive pkt_ready=1 from the first rising edge after rst_n deasserts.
REQ-033 SHALL, if reset asserts mid-packet in any state, discard the partial packet and buffer contents without resuming; the next packet SHALL start cleanly.

Verification
REQ-034 SHALL cover: header da=8'h02, sa=8'h11, len=0 -> sw_enable_out high for 3 cycles with data 02,11,00; pkt_done pulses next cycle; pkt_count=1.
REQ-035 SHALL cover: len=4, payload A0..A3 with pl_valid toggling every other cycle -> 7 contiguous enable cycles 02,11,04,A0,A1,A2,A3; 2 idle cycles; pkt_ready high afterwards.
REQ-036 SHALL cover: len=65 (FIFO_SIZE=64) -> err_oversize pulse, no sw_enable_out, pkt_count unchanged; then len=64 -> 67-byte frame, all bytes correct.
REQ-037 SHALL cover: reset asserted during TX_PL at byte 2 of 4 -> outputs 0 immediately; after release a new len=1 packet transmits correctly.
REQ-038 SHALL cover: pkt_valid held high continuously for back-to-back len=0 packets -> exactly IPG_CYCLES idle cycles plus one IDLE cycle between frames.
REQ-039 SHALL cover: pkt_count preloaded by forcing to 16'hFFFF -> one completion yields 0.
